// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl_pkg
// Brief    : Shared types and constants for the branch redirect controller.
// Revision : 1.0 - initial release
// ============================================================================
package branch_ctrl_pkg;

  localparam int unsigned PC_W_DEF  = 9;
  localparam int unsigned CNT_W_DEF = 16;
  // Wide all-ones source; counters slice their own width from it.
  localparam logic [63:0] CNT_MAX   = '1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                taken;
  } upd_entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : branch_upd_fifo
// Brief    : Small FIFO buffering predictor updates; head read from storage.
// Revision : 1.0 - initial release
// ============================================================================
module branch_upd_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = logic
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t       r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : Resolves branch/jump predictions, sequences redirect + flush,
//            queues predictor updates and keeps branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned FLUSH_CYC  = 2,
  parameter int unsigned UPDQ_DEPTH = 2,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_pc_four,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             upd_drop,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_MAX[CNT_W-1:0];

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic        w_resolve;
  logic        w_is_branch;
  logic        w_mispredict;
  logic [31:0] w_correct_pc;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  upd_entry_t  w_push_entry;
  upd_entry_t  w_head;

  // Wrong-path instructions arriving during FLUSH never count as resolves.
  assign w_resolve    = ex_valid && (r_state == RUN);
  assign w_is_branch  = ex_branch && !ex_jump;
  assign w_mispredict = w_resolve &&
                        ((ex_pred_taken != ex_taken) ||
                         (ex_taken && (ex_pred_pc != ex_target)));
  assign w_correct_pc = ex_taken ? ex_target : ex_pc_four;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      RUN: begin
        if (w_mispredict) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = 3'(FLUSH_CYC - 1);
        end
      end
      FLUSH: begin
        if (r_flush_cnt == 3'd0) w_state_nxt = RUN;
        else                     w_flush_cnt_nxt = r_flush_cnt - 3'd1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign flush = (r_state == FLUSH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_drop       <= 1'b0;
      br_count       <= '0;
      mis_count      <= '0;
    end else begin
      redirect_valid <= w_mispredict;
      if (w_mispredict) redirect_pc <= w_correct_pc;
      upd_drop <= w_push && w_full && !w_pop;
      if (w_resolve && (br_count != c_cnt_max))     br_count  <= br_count + 1'b1;
      if (w_mispredict && (mis_count != c_cnt_max)) mis_count <= mis_count + 1'b1;
    end
  end

  // Mispredicted branches still train the predictor with the real outcome.
  assign w_push             = w_resolve && w_is_branch;
  assign w_pop              = upd_valid && upd_ready;
  assign w_push_entry.pc    = ex_pc;
  assign w_push_entry.taken = ex_taken;

  branch_upd_fifo #(
    .DEPTH   (UPDQ_DEPTH),
    .entry_t (upd_entry_t)
  ) u_upd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign upd_valid = !w_empty;
  assign upd_pc    = w_head.pc;
  assign upd_taken = w_head.taken;

  a_branch_jump_exclusive : assert property (
    @(posedge clk) disable iff (!reset) !(ex_valid && ex_branch && ex_jump))
    else $error("branch_redirect_ctrl: ex_branch and ex_jump both asserted");

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_ctrl
// Brief    : Directed and randomized bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

  localparam int unsigned PC_W       = 9;
  localparam int unsigned FLUSH_CYC  = 2;
  localparam int unsigned UPDQ_DEPTH = 2;
  localparam int unsigned CNT_W      = 16;
  localparam longint     CNT_SAT     = (longint'(1) << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0;
  logic             ex_pred_taken = 1'b0, ex_taken = 1'b0;
  logic [31:0]      ex_pred_pc = '0, ex_target = '0, ex_pc_four = '0;
  logic [PC_W-1:0]  ex_pc = '0;
  logic             upd_ready = 1'b0;
  logic             redirect_valid, flush, upd_valid, upd_taken, upd_drop;
  logic [31:0]      redirect_pc;
  logic [PC_W-1:0]  upd_pc;
  logic [CNT_W-1:0] br_count, mis_count;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC), .UPDQ_DEPTH(UPDQ_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
    .ex_pc_four(ex_pc_four),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_drop(upd_drop),
    .br_count(br_count), .mis_count(mis_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining flush cycles, a plain queue of pending updates.
  typedef struct { logic [PC_W-1:0] pc; logic taken; } ent_t;
  ent_t        q[$];
  int          m_flush_rem;
  logic        m_rv, m_drop;
  logic [31:0] m_rpc;
  longint      m_br, m_mis;

  task automatic model_reset();
    q.delete();
    m_flush_rem = 0; m_rv = 0; m_drop = 0; m_rpc = '0; m_br = 0; m_mis = 0;
  endtask

  // Called just after a negedge: applies inputs, advances the model, steps one cycle.
  task automatic step(input logic v, input logic br, input logic jp, input logic pt,
                      input logic [31:0] ppc, input logic tk, input logic [31:0] tgt,
                      input logic [PC_W-1:0] pc, input logic [31:0] pc4, input logic rdy);
    logic ev, mis, popped, push;
    int   sz;
    ex_valid = v; ex_branch = br; ex_jump = jp; ex_pred_taken = pt; ex_pred_pc = ppc;
    ex_taken = tk; ex_target = tgt; ex_pc = pc; ex_pc_four = pc4; upd_ready = rdy;
    ev     = v && (m_flush_rem == 0);
    mis    = ev && ((pt != tk) || (tk && (ppc != tgt)));
    push   = ev && br && !jp;
    sz     = q.size();
    popped = (sz > 0) && rdy;
    if (popped) void'(q.pop_front());
    m_drop = 0;
    if (push) begin
      if (sz == int'(UPDQ_DEPTH) && !popped) m_drop = 1;
      else q.push_back('{pc: pc, taken: tk});
    end
    m_rv = mis;
    if (mis) m_rpc = tk ? tgt : pc4;
    if (mis)                  m_flush_rem = FLUSH_CYC;
    else if (m_flush_rem > 0) m_flush_rem--;
    if (ev  && m_br  < CNT_SAT) m_br++;
    if (mis && m_mis < CNT_SAT) m_mis++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, '0, 0, '0, '0, '0, rdy);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'($urandom); ex_branch = 1'($urandom); ex_jump = 1'($urandom);
      ex_pred_taken = 1'($urandom); ex_taken = 1'($urandom); upd_ready = 1'($urandom);
      ex_pred_pc = $urandom; ex_target = $urandom; ex_pc_four = $urandom;
      ex_pc = PC_W'($urandom);
      @(negedge clk);
      n_tests++;
      if ({redirect_valid, redirect_pc, flush, upd_valid, upd_pc, upd_taken, upd_drop,
           br_count, mis_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: rv=%b rpc=%h fl=%b uv=%b upc=%h ut=%b drop=%b br=%0d mis=%0d, all 0 required",
                 i, redirect_valid, redirect_pc, flush, upd_valid, upd_pc, upd_taken,
                 upd_drop, br_count, mis_count);
      end
    end
    ex_valid = 0; ex_branch = 0; ex_jump = 0; upd_ready = 0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({redirect_valid, flush, upd_valid, upd_drop, br_count, mis_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: rv=%b fl=%b uv=%b drop=%b br=%0d mis=%0d, all 0 required",
               redirect_valid, flush, upd_valid, upd_drop, br_count, mis_count);
    end
  endtask

  task automatic test_correct_pred();
    step(1, 1, 0, 1, 32'h40, 1, 32'h40, 9'h10, 32'h14, 1);
    n_tests++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL correct_no_redirect: rv=%b fl=%b, required 0 0", redirect_valid, flush);
    end
    n_tests++;
    if (br_count !== 16'd1 || mis_count !== 16'd0) begin
      n_fail++;
      $display("FAIL correct_counts: br=%0d mis=%0d, required 1 0", br_count, mis_count);
    end
    n_tests++;
    if (upd_valid !== 1'b1 || upd_pc !== 9'h10 || upd_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL correct_update: uv=%b upc=%h ut=%b, required 1 010 1",
               upd_valid, upd_pc, upd_taken);
    end
    idle(1);
    n_tests++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL correct_popped: uv=%b, required 0", upd_valid);
    end
  endtask

  task automatic test_mispredict();
    longint br0, mis0;
    br0 = m_br; mis0 = m_mis;
    step(1, 1, 0, 1, 32'h40, 0, 32'h40, 9'h10, 32'h14, 0);
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h14 || flush !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_redirect: rv=%b rpc=%h fl=%b, required 1 00000014 1",
               redirect_valid, redirect_pc, flush);
    end
    // Wrong-path mispredicting branch during flush must leave no trace.
    step(1, 1, 0, 0, 32'h0, 1, 32'h99, 9'h55, 32'h58, 0);
    n_tests++;
    if (redirect_valid !== 1'b0 || flush !== 1'b1 || redirect_pc !== 32'h14) begin
      n_fail++;
      $display("FAIL mis_flush2: rv=%b fl=%b rpc=%h, required 0 1 00000014",
               redirect_valid, flush, redirect_pc);
    end
    n_tests++;
    if (br_count !== CNT_W'(br0 + 1) || mis_count !== CNT_W'(mis0 + 1)) begin
      n_fail++;
      $display("FAIL mis_counts: br=%0d mis=%0d, required %0d %0d",
               br_count, mis_count, br0 + 1, mis0 + 1);
    end
    idle(0);
    n_tests++;
    if (flush !== 1'b0 || upd_valid !== 1'b1 || upd_pc !== 9'h10 || upd_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_after: fl=%b uv=%b upc=%h ut=%b, required 0 1 010 0",
               flush, upd_valid, upd_pc, upd_taken);
    end
    idle(1);
    n_tests++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_single_entry: uv=%b, required 0", upd_valid);
    end
  endtask

  task automatic test_jalr();
    longint mis0;
    mis0 = m_mis;
    step(1, 0, 1, 1, 32'h80, 1, 32'h84, 9'h20, 32'h24, 1);
    n_tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h84 || mis_count !== CNT_W'(mis0 + 1)) begin
      n_fail++;
      $display("FAIL jalr_redirect: rv=%b rpc=%h mis=%0d, required 1 00000084 %0d",
               redirect_valid, redirect_pc, mis_count, mis0 + 1);
    end
    n_tests++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_no_update: uv=%b, required 0", upd_valid);
    end
    idle(0); idle(0);
  endtask

  task automatic test_queue_full();
    logic [PC_W-1:0] pcs [3];
    pcs[0] = 9'h04; pcs[1] = 9'h08; pcs[2] = 9'h0C;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 32'h0, 0, 32'h0, pcs[i], 32'(pcs[i]) + 32'd4, 0);
      n_tests++;
      if (upd_drop !== (i == 2)) begin
        n_fail++;
        $display("FAIL qfull_drop_%0d: drop=%b, required %b", i, upd_drop, (i == 2));
      end
    end
    n_tests++;
    if (upd_valid !== 1'b1 || upd_pc !== 9'h04) begin
      n_fail++;
      $display("FAIL qfull_head0: uv=%b upc=%h, required 1 004", upd_valid, upd_pc);
    end
    idle(1);
    n_tests++;
    if (upd_drop !== 1'b0 || upd_valid !== 1'b1 || upd_pc !== 9'h08) begin
      n_fail++;
      $display("FAIL qfull_head1: drop=%b uv=%b upc=%h, required 0 1 008",
               upd_drop, upd_valid, upd_pc);
    end
    idle(1);
    n_tests++;
    if (upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL qfull_empty: uv=%b, required 0", upd_valid);
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 9'h30, 32'h34, 0);
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 9'h34, 32'h38, 0);
    step(1, 0, 1, 0, 32'h0, 1, 32'h200, 9'h38, 32'h3C, 0);
    n_tests++;
    if (flush !== 1'b1 || upd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: fl=%b uv=%b, required 1 1", flush, upd_valid);
    end
    ex_valid = 0; ex_branch = 0; ex_jump = 0;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (flush !== 1'b0 || upd_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: fl=%b uv=%b rv=%b, required 0 0 0",
               flush, upd_valid, redirect_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (br_count !== '0 || mis_count !== '0 || upd_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_after: br=%0d mis=%0d uv=%b fl=%b, required 0 0 0 0",
               br_count, mis_count, upd_valid, flush);
    end
  endtask

  task automatic test_random();
    logic v, jp, pt, tk;
    logic [31:0] ppc, tgt;
    logic [PC_W-1:0] pc;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 9) < 4);
      jp  = ($urandom_range(0, 3) == 0);
      pt  = 1'($urandom);
      tk  = jp ? 1'b1 : 1'($urandom);
      ppc = 32'h100 + 32'($urandom_range(0, 1)) * 32'd4;
      tgt = 32'h100 + 32'($urandom_range(0, 1)) * 32'd4;
      pc  = PC_W'($urandom);
      step(v, !jp, jp, pt, ppc, tk, tgt, pc, 32'(pc) + 32'd4, 1'($urandom_range(0, 2) != 0));
      n_tests++;
      if (redirect_valid !== m_rv || redirect_pc !== m_rpc || flush !== (m_flush_rem > 0)) begin
        n_fail++;
        $display("FAIL rand_redirect c%0d: rv=%b rpc=%h fl=%b, required %b %h %b",
                 c, redirect_valid, redirect_pc, flush, m_rv, m_rpc, (m_flush_rem > 0));
      end
      n_tests++;
      if (br_count !== CNT_W'(m_br) || mis_count !== CNT_W'(m_mis) || upd_drop !== m_drop) begin
        n_fail++;
        $display("FAIL rand_stats c%0d: br=%0d mis=%0d drop=%b, required %0d %0d %b",
                 c, br_count, mis_count, upd_drop, m_br, m_mis, m_drop);
      end
      n_tests++;
      if (upd_valid !== (q.size() > 0) ||
          (q.size() > 0 && (upd_pc !== q[0].pc || upd_taken !== q[0].taken))) begin
        n_fail++;
        $display("FAIL rand_update c%0d: uv=%b upc=%h ut=%b, required valid=%b (queue size %0d)",
                 c, upd_valid, upd_pc, upd_taken, (q.size() > 0), q.size());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_correct_pred();
    test_mispredict();
    test_jalr();
    test_queue_full();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
